// File: rtl/gf180mcu_oai31_chk_pkg.sv
// Shared types and golden function for the OAI cell vector checkers.
`timescale 1ns/1ps
package gf180mcu_oai31_chk_pkg;

    localparam int unsigned VEC_W    = 4;
    localparam int unsigned SETTLE_W = 4;
    localparam logic [VEC_W-1:0] LAST_VEC = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_SAMPLE,
        S_DONE
    } chk_state_t;

    // Stimulus bus; field order matches the vector bit order A1=v[3] .. B=v[0].
    typedef struct packed {
        logic a1;
        logic a2;
        logic a3;
        logic b;
    } oai31_stim_t;

    // Golden 3-1 OR-AND-invert response for one input vector.
    function automatic logic oai31_expected(input logic [VEC_W-1:0] v);
        return ~((v[3] | v[2] | v[1]) & v[0]);
    endfunction

endpackage

// File: rtl/gf180mcu_oai31_ref_model.sv
// Combinational golden model: 4-bit input vector to expected ZN.
`timescale 1ns/1ps
module gf180mcu_oai31_ref_model
    import gf180mcu_oai31_chk_pkg::*;
(
    input  logic [VEC_W-1:0] vec,
    output logic             exp_zn_c
);

    // Pure lookup of the golden function for the vector currently applied.
    always_comb begin
        exp_zn_c = oai31_expected(vec);
    end

endmodule

// File: rtl/gf180mcu_oai31_vector_checker.sv
// Sweeps all 16 input vectors into an OAI31 cell, samples ZN after a settle
// time and records mismatches against the golden model.
`timescale 1ns/1ps
module gf180mcu_oai31_vector_checker
    import gf180mcu_oai31_chk_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned ERR_CNT_W     = 5
) (
    input  logic                 CLK,
    input  logic                 RN,
    input  logic                 START,
    output logic                 A1,
    output logic                 A2,
    output logic                 A3,
    output logic                 B,
    input  logic                 ZN,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 PASS,
    output logic [ERR_CNT_W-1:0] ERR_CNT,
    output logic                 FAIL_VALID,
    output logic [VEC_W-1:0]     FIRST_FAIL_VEC
);

    localparam logic [SETTLE_W-1:0]  SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX     = '1;

    chk_state_t           state_q, state_d;
    logic [VEC_W-1:0]     vec_q, vec_d;
    logic [SETTLE_W-1:0]  settle_q, settle_d;
    oai31_stim_t          stim_q, stim_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 pass_q, pass_d;
    logic [ERR_CNT_W-1:0] err_q, err_d;
    logic                 fail_valid_q, fail_valid_d;
    logic [VEC_W-1:0]     first_fail_q, first_fail_d;

    logic                 exp_zn_c;
    logic                 mismatch_c;

    gf180mcu_oai31_ref_model u_ref (
        .vec      (vec_q),
        .exp_zn_c (exp_zn_c)
    );

    // Case-inequality so an unknown or floating ZN is scored as a mismatch.
    always_comb begin
        mismatch_c = (ZN !== exp_zn_c);
    end

    // Next-state, counters and result bookkeeping.
    always_comb begin
        state_d      = state_q;
        vec_d        = vec_q;
        settle_d     = settle_q;
        err_d        = err_q;
        fail_valid_d = fail_valid_q;
        first_fail_d = first_fail_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (START) begin
                    state_d      = S_HOLD;
                    vec_d        = '0;
                    settle_d     = '0;
                    err_d        = '0;
                    fail_valid_d = 1'b0;
                    first_fail_d = '0;
                end
            end
            S_HOLD: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d  = S_SAMPLE;
                    settle_d = '0;
                end else begin
                    settle_d = settle_q + SETTLE_W'(1);
                end
            end
            S_SAMPLE: begin
                if (mismatch_c) begin
                    if (err_q != ERR_MAX) begin
                        err_d = err_q + ERR_CNT_W'(1);
                    end
                    if (!fail_valid_q) begin
                        fail_valid_d = 1'b1;
                        first_fail_d = vec_q;
                    end
                end
                if (vec_q == LAST_VEC) begin
                    state_d = S_DONE;
                end else begin
                    vec_d   = vec_q + VEC_W'(1);
                    state_d = S_HOLD;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_HOLD) || (state_d == S_SAMPLE);
        done_d = (state_d == S_DONE);
        pass_d = done_d && (err_d == '0);
        stim_d = busy_d ? oai31_stim_t'(vec_d) : '0;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RN) begin
            state_q      <= S_IDLE;
            vec_q        <= '0;
            settle_q     <= '0;
            stim_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_q        <= '0;
            fail_valid_q <= 1'b0;
            first_fail_q <= '0;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            settle_q     <= settle_d;
            stim_q       <= stim_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_q        <= err_d;
            fail_valid_q <= fail_valid_d;
            first_fail_q <= first_fail_d;
        end
    end

    assign A1             = stim_q.a1;
    assign A2             = stim_q.a2;
    assign A3             = stim_q.a3;
    assign B              = stim_q.b;
    assign BUSY           = busy_q;
    assign DONE           = done_q;
    assign PASS           = pass_q;
    assign ERR_CNT        = err_q;
    assign FAIL_VALID     = fail_valid_q;
    assign FIRST_FAIL_VEC = first_fail_q;

endmodule

// File: doc/gf180mcu_oai31_vector_checker.md
Name: gf180mcu_oai31_vector_checker

Overview:
- Sequential stimulus and capture harness for the 3-1 OR-AND-invert cell in the 9-track 5V library.
- Upstream side: drives A1, A2, A3 and B of a cell under test through all 16 input combinations.
- Downstream side: samples ZN after a programmable settle time and compares it with the golden function ZN = ~((A1|A2|A3)&B).
- Used in on-chip cell characterisation and bring-up test structures.

Parameters:
- SETTLE_CYCLES, 2: cycles each vector is held before ZN is sampled; legal range 1..15.
- ERR_CNT_W, 5: width of the mismatch counter; the counter saturates.

Ports:
- CLK  in  1  rising-edge clock.
- RN  in  1  synchronous active-low reset.
- START  in  1  begins a sweep; sampled only in IDLE or DONE.
- A1, A2, A3, B  out  1 each  stimulus to the cell under test.
- ZN  in  1  response from the cell under test.
- BUSY  out  1  high while a sweep is in progress.
- DONE  out  1  high after a sweep completes; held until the next START or reset.
- PASS  out  1  valid when DONE=1; high iff ERR_CNT==0.
- ERR_CNT  out  ERR_CNT_W  number of mismatching vectors, saturating.
- FAIL_VALID  out  1  high once any mismatch has been recorded in the current sweep.
- FIRST_FAIL_VEC  out  4  vector index of the first mismatch.

Behaviour:
- Reset: synchronous, active-low, one clock and one reset only.
  - RN low at a rising edge sets all state and outputs to zero on that edge: A1..B, BUSY, DONE, PASS, ERR_CNT, FAIL_VALID, FIRST_FAIL_VEC.
  - The state machine goes to IDLE.
  - RN low mid-sweep aborts the sweep with no partial DONE.
- Vector index v is 4 bits: A1=v[3], A2=v[2], A3=v[1], B=v[0]. Vectors are swept in order 0 to 15.
- Golden result: expected ZN=0 for v in {3,5,7,9,11,13,15} and 1 for every other v.
- States: IDLE, HOLD, SAMPLE, DONE.
  - IDLE: stimulus is all zeros. START=1 moves to HOLD with v=0, and the edge that does this clears ERR_CNT, FAIL_VALID and FIRST_FAIL_VEC. BUSY goes high on that same edge.
  - HOLD: stimulus = v. A settle counter counts SETTLE_CYCLES cycles, then the machine moves to SAMPLE.
  - SAMPLE: stimulus is still v. On this edge ZN is compared with the expected value.
    - On mismatch, ERR_CNT increments and saturates at 2^ERR_CNT_W-1.
    - On the first mismatch, FIRST_FAIL_VEC←v and FAIL_VALID←1.
    - If v==15 the machine goes to DONE. Otherwise v←v+1 and it returns to HOLD.
  - DONE: BUSY=0, DONE=1, PASS=(ERR_CNT==0), and the stimulus returns to all zeros. START=1 starts a new sweep exactly as from IDLE and clears DONE and PASS.
- Each vector occupies SETTLE_CYCLES+1 cycles. With the default, a sweep is BUSY for 48 cycles.
- START while BUSY is ignored. START held high in DONE restarts immediately.
- The v counter does not wrap into a new sweep; 15 always terminates.
- Stimulus outputs are registered and change only on clock edges.
- ZN is sampled directly, with no synchroniser. The settle time covers cell delay.
- In simulation, ZN=X or Z counts as a mismatch: the comparison uses case-inequality semantics.
- PASS is low whenever DONE is low.

Decomposition:
- Shared package gf180mcu_oai31_chk_pkg holds:
  - the state enum (IDLE, HOLD, SAMPLE, DONE);
  - VEC_W=4 and LAST_VEC=4'hF;
  - a function oai31_expected(v) returning ~((v[3]|v[2]|v[1])&v[0]).
- One sub-module, gf180mcu_oai31_ref_model: a combinational golden model mapping the 4-bit vector to expected ZN. It is reused by the future oai21/oai32 checkers.
- The FSM, counters and result registers live in the top.

Test Plan:
- Correct oai31 functional model looped back, default parameters, START pulse → BUSY for 48 cycles, then DONE=1, PASS=1, ERR_CNT=0, FAIL_VALID=0.
- ZN stuck at 1 → DONE, ERR_CNT=7, FIRST_FAIL_VEC=3, FAIL_VALID=1, PASS=0.
- ZN stuck at 0 → ERR_CNT=9, FIRST_FAIL_VEC=0. Inverted cell (ZN=~expected) → ERR_CNT=16.
- ERR_CNT_W=3 with an inverted cell → ERR_CNT saturates at 7 and does not wrap; FIRST_FAIL_VEC=0.
- RN low during vector 5 → next edge: all outputs 0, state IDLE. START afterwards restarts at v=0 and gives a clean PASS with a good cell.
- START pulsed at v=8 mid-sweep → ignored, sweep length unchanged. START held high in DONE → new sweep begins, DONE drops on the next edge, and ERR_CNT clears on that edge.
